// File: rtl/axi_single_beat_adapter.sv
// Request/grant to AXI4 bridge: single-beat bursts, one transaction in flight.
// Carries the AXI type packages it needs so the block stands alone.

package axi_pkg;
   typedef logic [2:0] size_t;
   typedef logic [1:0] burst_t;
   typedef logic [1:0] resp_t;
   localparam burst_t BURST_INCR  = 2'b01;
   localparam resp_t  RESP_OKAY   = 2'b00;
   localparam resp_t  RESP_EXOKAY = 2'b01;
   localparam resp_t  RESP_SLVERR = 2'b10;
   localparam resp_t  RESP_DECERR = 2'b11;
endpackage

package ariane_axi;
   localparam int IdWidth   = 4;
   localparam int AddrWidth = 48;
   localparam int DataWidth = 64;
   localparam int StrbWidth = 8;
   localparam int UserWidth = 1;

   typedef logic [IdWidth-1:0]   id_t;
   typedef logic [AddrWidth-1:0] addr_t;
   typedef logic [DataWidth-1:0] data_t;
   typedef logic [StrbWidth-1:0] strb_t;
   typedef logic [UserWidth-1:0] user_t;

   typedef struct packed {
      id_t             id;
      addr_t           addr;
      logic [7:0]      len;
      axi_pkg::size_t  size;
      axi_pkg::burst_t burst;
      logic            lock;
      logic [3:0]      cache;
      logic [2:0]      prot;
      logic [3:0]      qos;
      logic [3:0]      region;
      logic [5:0]      atop;
      user_t           user;
   } aw_chan_t;

   typedef struct packed {
      id_t             id;
      addr_t           addr;
      logic [7:0]      len;
      axi_pkg::size_t  size;
      axi_pkg::burst_t burst;
      logic            lock;
      logic [3:0]      cache;
      logic [2:0]      prot;
      logic [3:0]      qos;
      logic [3:0]      region;
      user_t           user;
   } ar_chan_t;

   typedef struct packed {
      data_t data;
      strb_t strb;
      logic  last;
      user_t user;
   } w_chan_t;

   typedef struct packed {
      id_t            id;
      axi_pkg::resp_t resp;
      user_t          user;
   } b_chan_t;

   typedef struct packed {
      id_t            id;
      data_t          data;
      axi_pkg::resp_t resp;
      logic           last;
      user_t          user;
   } r_chan_t;

   typedef struct packed {
      aw_chan_t aw;
      logic     aw_valid;
      w_chan_t  w;
      logic     w_valid;
      logic     b_ready;
      ar_chan_t ar;
      logic     ar_valid;
      logic     r_ready;
   } req_t;

   typedef struct packed {
      logic    aw_ready;
      logic    ar_ready;
      logic    w_ready;
      logic    b_valid;
      b_chan_t b;
      logic    r_valid;
      r_chan_t r;
   } resp_t;
endpackage

module axi_single_beat_adapter #(
   parameter logic [ariane_axi::IdWidth-1:0] AXI_ID    = 4'b0000,
   parameter logic [3:0]                     AXI_CACHE = 4'b0010
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               req_i,
   input  logic               we_i,
   input  logic [47:0]        addr_i,
   input  logic [63:0]        wdata_i,
   input  logic [7:0]         be_i,
   input  logic [2:0]         size_i,
   output logic               gnt_o,
   output logic               valid_o,
   output logic [63:0]        rdata_o,
   output logic               err_o,
   output ariane_axi::req_t   axi_req_o,
   input  ariane_axi::resp_t  axi_resp_i
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WR     = 3'd1,
      WAIT_B = 3'd2,
      RD     = 3'd3,
      WAIT_R = 3'd4
   } state_t;

   state_t       state_r;
   logic         aw_pending_r;
   logic         w_pending_r;
   logic         we_r;
   logic [47:0]  addr_r;
   logic [63:0]  wdata_r;
   logic [7:0]   be_r;
   logic [2:0]   size_r;
   logic         valid_r;
   logic         err_r;
   logic [63:0]  rdata_r;

   logic         aw_valid_s;
   logic         w_valid_s;
   logic         ar_valid_s;
   logic         aw_done_s;
   logic         w_done_s;
   logic         unused_s;

   assign gnt_o   = (state_r == IDLE) & req_i;
   assign valid_o = valid_r;
   assign err_o   = err_r;
   assign rdata_o = rdata_r;

   assign aw_valid_s = (state_r == WR) & we_r & aw_pending_r;
   assign w_valid_s  = (state_r == WR) & we_r & w_pending_r;
   assign ar_valid_s = (state_r == RD) & ~we_r;

   // A write channel is done once its flag is clear or it handshakes this cycle.
   assign aw_done_s = ~aw_pending_r | (aw_valid_s & axi_resp_i.aw_ready);
   assign w_done_s  = ~w_pending_r  | (w_valid_s  & axi_resp_i.w_ready);

   assign unused_s = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                       axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.resp[0]};

   // AXI request: payload only from holding regs, fixed single-beat attributes.
   always_comb begin
      axi_req_o           = '0;
      axi_req_o.aw.id     = AXI_ID;
      axi_req_o.aw.addr   = addr_r;
      axi_req_o.aw.len    = 8'd0;
      axi_req_o.aw.size   = size_r;
      axi_req_o.aw.burst  = axi_pkg::BURST_INCR;
      axi_req_o.aw.cache  = AXI_CACHE;
      axi_req_o.aw_valid  = aw_valid_s;
      axi_req_o.w.data    = wdata_r;
      axi_req_o.w.strb    = be_r;
      axi_req_o.w.last    = 1'b1;
      axi_req_o.w_valid   = w_valid_s;
      axi_req_o.b_ready   = (state_r == WAIT_B);
      axi_req_o.ar.id     = AXI_ID;
      axi_req_o.ar.addr   = addr_r;
      axi_req_o.ar.len    = 8'd0;
      axi_req_o.ar.size   = size_r;
      axi_req_o.ar.burst  = axi_pkg::BURST_INCR;
      axi_req_o.ar.cache  = AXI_CACHE;
      axi_req_o.ar_valid  = ar_valid_s;
      axi_req_o.r_ready   = (state_r == WAIT_R);
   end

   // Transaction FSM, holding registers and registered completion outputs.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         aw_pending_r <= 1'b0;
         w_pending_r  <= 1'b0;
         we_r         <= 1'b0;
         addr_r       <= 48'd0;
         wdata_r      <= 64'd0;
         be_r         <= 8'd0;
         size_r       <= 3'd0;
         valid_r      <= 1'b0;
         err_r        <= 1'b0;
         rdata_r      <= 64'd0;
      end else begin
         valid_r <= 1'b0;
         err_r   <= 1'b0;
         case (state_r)
            IDLE: begin
               if (req_i) begin
                  we_r    <= we_i;
                  addr_r  <= addr_i;
                  wdata_r <= wdata_i;
                  be_r    <= be_i;
                  size_r  <= size_i;
                  if (we_i) begin
                     state_r      <= WR;
                     aw_pending_r <= 1'b1;
                     w_pending_r  <= 1'b1;
                  end else begin
                     state_r <= RD;
                  end
               end
            end
            WR: begin
               if (aw_done_s) aw_pending_r <= 1'b0;
               if (w_done_s)  w_pending_r  <= 1'b0;
               if (aw_done_s && w_done_s) state_r <= WAIT_B;
            end
            WAIT_B: begin
               if (axi_resp_i.b_valid) begin
                  valid_r <= 1'b1;
                  err_r   <= axi_resp_i.b.resp[1];
                  state_r <= IDLE;
               end
            end
            RD: begin
               if (axi_resp_i.ar_ready) state_r <= WAIT_R;
            end
            WAIT_R: begin
               if (axi_resp_i.r_valid) begin
                  valid_r <= 1'b1;
                  rdata_r <= axi_resp_i.r.data;
                  // A missing last on a single-beat read is a protocol error.
                  err_r   <= axi_resp_i.r.resp[1] | ~axi_resp_i.r.last;
                  state_r <= IDLE;
               end
            end
            default: begin
               state_r      <= IDLE;
               aw_pending_r <= 1'b0;
               w_pending_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi_single_beat_adapter.sv
// Directed bench for axi_single_beat_adapter with a completion scoreboard.

module tb_axi_single_beat_adapter;

   logic               clk = 1'b0;
   logic               rst;
   logic               req;
   logic               we;
   logic [47:0]        addr;
   logic [63:0]        wdata;
   logic [7:0]         be;
   logic [2:0]         size;
   logic               gnt_o;
   logic               valid_o;
   logic [63:0]        rdata_o;
   logic               err_o;
   ariane_axi::req_t   axi_req;
   ariane_axi::resp_t  axi_resp;

   int checks = 0;
   int errors = 0;
   int aw_cnt = 0;
   int w_cnt  = 0;
   int ar_cnt = 0;
   logic [64:0] exp_q[$];
   logic [63:0] model_rdata = 64'd0;

   always #5 clk = ~clk;

   axi_single_beat_adapter #(.AXI_ID(4'b0000), .AXI_CACHE(4'b0010)) dut (
      .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .addr_i(addr),
      .wdata_i(wdata), .be_i(be), .size_i(size), .gnt_o(gnt_o),
      .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o),
      .axi_req_o(axi_req), .axi_resp_i(axi_resp)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Handshake counters on the AXI side
   always @(posedge clk) begin
      if (!rst) begin
         if (axi_req.aw_valid && axi_resp.aw_ready) aw_cnt <= aw_cnt + 1;
         if (axi_req.w_valid  && axi_resp.w_ready)  w_cnt  <= w_cnt + 1;
         if (axi_req.ar_valid && axi_resp.ar_ready) ar_cnt <= ar_cnt + 1;
      end
   end

   // Scoreboard: every completion pulse must match the oldest expectation
   always @(negedge clk) begin
      if (valid_o === 1'b1) begin
         chk("unexpected_valid", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) begin
            logic [64:0] e;
            e = exp_q.pop_front();
            chk("sb_rdata", rdata_o, e[64:1]);
            chk("sb_err", 64'(err_o), 64'(e[0]));
         end
      end
   end

   task automatic wait_valid(input string tag);
      int n = 0;
      smp();
      while (valid_o !== 1'b1 && n < 20) begin
         smp();
         n++;
      end
      chk({tag, "_done"}, 64'(valid_o), 64'd1);
   endtask

   task automatic read_txn(input logic [47:0] a, input logic [63:0] d,
                           input logic [1:0] rs, input logic lst, input logic e);
      cyc();
      axi_resp.ar_ready = 1'b1;
      axi_resp.r_valid  = 1'b1;
      axi_resp.r.data   = d;
      axi_resp.r.resp   = rs;
      axi_resp.r.last   = lst;
      exp_q.push_back({d, e});
      model_rdata = d;
      req = 1'b1; we = 1'b0; addr = a; size = 3'd3;
      smp();
      chk("rd_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      wait_valid("rd");
      cyc();
      axi_resp = '0;
   endtask

   task automatic write_txn(input logic [47:0] a, input logic [63:0] d,
                            input logic [1:0] rs, input logic e);
      cyc();
      axi_resp.aw_ready = 1'b1;
      axi_resp.w_ready  = 1'b1;
      axi_resp.b_valid  = 1'b1;
      axi_resp.b.resp   = rs;
      exp_q.push_back({model_rdata, e});
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = 8'hFF; size = 3'd3;
      smp();
      chk("wr_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      wait_valid("wr");
      cyc();
      axi_resp = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int aw0, w0, ar0;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = 48'd0; wdata = 64'd0;
      be = 8'd0; size = 3'd0; axi_resp = '0;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_err", 64'(err_o), 64'd0);
      chk("rst_rdata", rdata_o, 64'd0);
      chk("rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                             axi_req.b_ready, axi_req.r_ready}), 64'd0);
      cyc();
      rst = 1'b0;

      // Write with immediate slave: grant c0, AW+W c1, B c2, valid_o c3
      axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
      axi_resp.b_valid = 1'b1; axi_resp.b.resp = axi_pkg::RESP_OKAY;
      exp_q.push_back({model_rdata, 1'b0});
      req = 1'b1; we = 1'b1; addr = 48'h0000_8000_0010;
      wdata = 64'hDEAD_BEEF_0000_1111; be = 8'hFF; size = 3'd3;
      smp();
      chk("t1_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      smp();
      chk("t1_aw_valid", 64'(axi_req.aw_valid), 64'd1);
      chk("t1_w_valid", 64'(axi_req.w_valid), 64'd1);
      chk("t1_aw_len", 64'(axi_req.aw.len), 64'd0);
      chk("t1_w_last", 64'(axi_req.w.last), 64'd1);
      chk("t1_aw_addr", 64'(axi_req.aw.addr), 64'h0000_0000_8000_0010);
      chk("t1_w_data", axi_req.w.data, 64'hDEAD_BEEF_0000_1111);
      chk("t1_aw_attr", 64'({axi_req.aw.burst, axi_req.aw.cache, axi_req.aw.size}),
          64'({2'b01, 4'b0010, 3'd3}));
      chk("t1_gnt_busy", 64'(gnt_o), 64'd0);
      cyc();
      smp();
      chk("t1_b_ready", 64'(axi_req.b_ready), 64'd1);
      chk("t1_aw_drop", 64'(axi_req.aw_valid), 64'd0);
      cyc();
      smp();
      chk("t1_valid", 64'(valid_o), 64'd1);
      chk("t1_err", 64'(err_o), 64'd0);
      cyc();
      axi_resp = '0;
      smp();
      chk("t1_pulse", 64'(valid_o), 64'd0);

      // Write where W completes before AW
      cyc();
      aw0 = aw_cnt; w0 = w_cnt;
      axi_resp.w_ready = 1'b1;
      req = 1'b1; we = 1'b1; addr = 48'h0000_8000_0020;
      wdata = 64'h1122_3344_5566_7788; be = 8'h0F; size = 3'd2;
      smp();
      chk("t2_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      smp();
      chk("t2_both_valid", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'd3);
      cyc();
      smp();
      chk("t2_w_dropped", 64'(axi_req.w_valid), 64'd0);
      chk("t2_aw_held", 64'(axi_req.aw_valid), 64'd1);
      cyc();
      axi_resp.aw_ready = 1'b1;
      smp();
      chk("t2_aw_strb", 64'({axi_req.aw_valid, axi_req.w.strb}), 64'h10F);
      cyc();
      axi_resp.aw_ready = 1'b0;
      smp();
      chk("t2_wait_b", 64'({axi_req.aw_valid, axi_req.b_ready, valid_o}), 64'd2);
      cyc();
      axi_resp.b_valid = 1'b1; axi_resp.b.resp = axi_pkg::RESP_OKAY;
      exp_q.push_back({model_rdata, 1'b0});
      smp();
      chk("t2_no_early_valid", 64'(valid_o), 64'd0);
      cyc();
      axi_resp = '0;
      smp();
      chk("t2_valid", 64'(valid_o), 64'd1);
      chk("t2_aw_count", 64'(aw_cnt - aw0), 64'd1);
      chk("t2_w_count", 64'(w_cnt - w0), 64'd1);

      // Read with 5 wait cycles before R
      cyc();
      axi_resp.ar_ready = 1'b1;
      req = 1'b1; we = 1'b0; addr = 48'h0000_1000_0000; size = 3'd3;
      smp();
      chk("t3_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      smp();
      chk("t3_ar", 64'({axi_req.ar_valid, axi_req.ar.len}), 64'h100);
      chk("t3_ar_addr", 64'(axi_req.ar.addr), 64'h0000_0000_1000_0000);
      for (int i = 0; i < 5; i++) begin
         cyc();
         axi_resp.ar_ready = 1'b0;
         smp();
         chk("t3_wait", 64'({axi_req.r_ready, axi_req.ar_valid, valid_o}), 64'd4);
      end
      cyc();
      axi_resp.r_valid = 1'b1; axi_resp.r.data = 64'h0123_4567_89AB_CDEF;
      axi_resp.r.resp = axi_pkg::RESP_OKAY; axi_resp.r.last = 1'b1;
      exp_q.push_back({64'h0123_4567_89AB_CDEF, 1'b0});
      model_rdata = 64'h0123_4567_89AB_CDEF;
      cyc();
      axi_resp = '0;
      smp();
      chk("t3_valid", 64'(valid_o), 64'd1);
      chk("t3_rdata", rdata_o, 64'h0123_4567_89AB_CDEF);
      cyc();
      smp();
      chk("t3_pulse", 64'(valid_o), 64'd0);

      // Error responses and the missing-last case
      read_txn(48'h0000_2000_0040, 64'hCAFE_F00D_0000_0001, axi_pkg::RESP_DECERR, 1'b1, 1'b1);
      write_txn(48'h0000_2000_0080, 64'h5A5A_5A5A_A5A5_A5A5, axi_pkg::RESP_SLVERR, 1'b1);
      read_txn(48'h0000_2000_00C0, 64'h0000_0000_FFFF_0000, axi_pkg::RESP_EXOKAY, 1'b1, 1'b0);
      read_txn(48'h0000_2000_0100, 64'h7777_8888_9999_AAAA, axi_pkg::RESP_OKAY, 1'b0, 1'b1);

      // Back-to-back reads with req held high
      cyc();
      ar0 = ar_cnt;
      axi_resp.ar_ready = 1'b1; axi_resp.r_valid = 1'b1; axi_resp.r.last = 1'b1;
      axi_resp.r.resp = axi_pkg::RESP_OKAY; axi_resp.r.data = 64'hAAAA_0000_0000_0001;
      exp_q.push_back({64'hAAAA_0000_0000_0001, 1'b0});
      model_rdata = 64'hAAAA_0000_0000_0001;
      req = 1'b1; we = 1'b0; addr = 48'h0000_3000_0000;
      smp();
      chk("t5_gnt0", 64'(gnt_o), 64'd1);
      cyc();
      smp();
      chk("t5_rd", 64'({gnt_o, axi_req.ar_valid}), 64'd1);
      cyc();
      addr = 48'h0000_3000_0008;
      smp();
      chk("t5_wait_r", 64'({gnt_o, axi_req.ar_valid, axi_req.r_ready}), 64'd1);
      chk("t5_one_ar", 64'(ar_cnt - ar0), 64'd1);
      cyc();
      axi_resp.r.data = 64'hBBBB_0000_0000_0002;
      exp_q.push_back({64'hBBBB_0000_0000_0002, 1'b0});
      model_rdata = 64'hBBBB_0000_0000_0002;
      smp();
      chk("t5_b2b_gnt", 64'({valid_o, gnt_o, axi_req.ar_valid}), 64'd6);
      cyc();
      req = 1'b0;
      smp();
      chk("t5_ar2_addr", 64'({axi_req.ar_valid, axi_req.ar.addr}), {15'd0, 1'b1, 48'h0000_3000_0008});
      wait_valid("t5_second");
      cyc();
      axi_resp = '0;
      chk("t5_ar_total", 64'(ar_cnt - ar0), 64'd2);

      // Reset while waiting for R
      cyc();
      axi_resp.ar_ready = 1'b1;
      req = 1'b1; we = 1'b0; addr = 48'h0000_4000_0000;
      smp();
      chk("t6_gnt", 64'(gnt_o), 64'd1);
      cyc();
      req = 1'b0;
      cyc();
      axi_resp.ar_ready = 1'b0;
      smp();
      chk("t6_in_wait_r", 64'(axi_req.r_ready), 64'd1);
      cyc();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      model_rdata = 64'd0;
      smp();
      chk("t6_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid,
                            axi_req.b_ready, axi_req.r_ready, valid_o}), 64'd0);
      chk("t6_rdata", rdata_o, 64'd0);
      read_txn(48'h0000_4000_0010, 64'h0F0F_0F0F_F0F0_F0F0, axi_pkg::RESP_OKAY, 1'b1, 1'b0);

      repeat (3) cyc();
      chk("sb_empty", 64'(exp_q.size()), 64'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
